pc_sequencer: RTL and testbench

- Program-counter stage of the single-cycle processor. It holds the architectural PC and computes next-PC from increment, branch and jump requests.
- Sits directly upstream of instruction memory fetch. It consumes control and branch results from the decode/execute path.
- Internally it is the registered PC (async-reset flip-flop bank) plus next-PC selection and a small run/halt state machine.

---
 rtl/pc_sequencer_pkg.sv | 15 +
 rtl/pc_sequencer_pc_reg.sv | 26 ++
 rtl/pc_sequencer.sv | 129 ++++++++++++
 tb/tb_pc_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the PC sequencer and neighbouring stages.
// Holds the run/halt state encoding plus default width, reset vector and step.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_t;

    localparam int          PC_WIDTH     = 32;
    localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
    localparam int          PC_STEP      = 4;

endpackage

// File: rtl/pc_sequencer_pc_reg.sv
// Architectural PC flip-flop bank with load enable.
// Ports: clk, rst (async active-low, loads RESET_VEC), i_load, i_d, o_q.
module pc_sequencer_pc_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= RESET_VEC;
        end else if (i_load) begin
            r_pc <= i_d;
        end
    end

    assign o_q = r_pc;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage: registered PC, next-PC select, BOOT/RUN/HALT FSM.
// Ports: clk, rst (async active-low), stall, branch_taken, branch_off, jump,
//   jump_tgt, halt, resume -> pc, pc_plus_step, fetch_valid, halted.
// Optional macro PC_ALIGN_TRAP_EN adds output misalign: a misaligned
//   jump/branch target holds pc, sets misalign and halts; resume clears it.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int               WIDTH     = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC),
    parameter int               STEP      = PC_STEP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_off,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_tgt,
    input  logic             halt,
    input  logic             resume,
`ifdef PC_ALIGN_TRAP_EN
    output logic             misalign,
`endif
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus_step,
    output logic             fetch_valid,
    output logic             halted
);

    pc_state_t        r_state;
    logic             r_fetch_valid;
    logic             r_halted;
    logic [WIDTH-1:0] w_pc;
    logic [WIDTH-1:0] w_next;
    logic             w_redirect;
    logic             w_trap;
    logic             w_load;

    assign pc_plus_step = w_pc + WIDTH'(STEP);
    assign w_redirect   = jump | branch_taken;

    // Jump beats branch; branch offset wraps modulo 2^WIDTH.
    always_comb begin
        w_next = pc_plus_step;
        if (jump) begin
            w_next = jump_tgt;
        end else if (branch_taken) begin
            w_next = w_pc + branch_off;
        end
    end

`ifdef PC_ALIGN_TRAP_EN
    assign w_trap = w_redirect && (w_next[1:0] != 2'b00);
`else
    assign w_trap = 1'b0;
`endif

    assign w_load = (r_state == ST_RUN) && !halt && !stall && !w_trap;

    pc_sequencer_pc_reg #(
        .WIDTH     (WIDTH),
        .RESET_VEC (RESET_VEC)
    ) u_pc_reg (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_d    (w_next),
        .o_q    (w_pc)
    );

`ifdef PC_ALIGN_TRAP_EN
    logic r_misalign;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_BOOT;
            r_fetch_valid <= 1'b0;
            r_halted      <= 1'b0;
`ifdef PC_ALIGN_TRAP_EN
            r_misalign    <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                ST_BOOT: begin
                    r_state       <= ST_RUN;
                    r_fetch_valid <= 1'b1;
                    r_halted      <= 1'b0;
                end
                ST_RUN: begin
                    if (halt || (!stall && w_trap)) begin
                        r_state       <= ST_HALT;
                        r_fetch_valid <= 1'b0;
                        r_halted      <= 1'b1;
`ifdef PC_ALIGN_TRAP_EN
                        if (!halt) begin
                            r_misalign <= 1'b1;
                        end
`endif
                    end
                end
                ST_HALT: begin
                    if (resume) begin
                        r_state       <= ST_RUN;
                        r_fetch_valid <= 1'b1;
                        r_halted      <= 1'b0;
`ifdef PC_ALIGN_TRAP_EN
                        r_misalign    <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_state       <= ST_BOOT;
                    r_fetch_valid <= 1'b0;
                    r_halted      <= 1'b0;
                end
            endcase
        end
    end

    assign pc          = w_pc;
    assign fetch_valid = r_fetch_valid;
    assign halted      = r_halted;
`ifdef PC_ALIGN_TRAP_EN
    assign misalign    = r_misalign;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
// Covers reset/BOOT, stall, branch/jump priority, wrap, halt/resume, async reset.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_off;
    logic        jump;
    logic [31:0] jump_tgt;
    logic        halt;
    logic        resume;
    logic [31:0] pc;
    logic [31:0] pc_plus_step;
    logic        fetch_valid;
    logic        halted;
`ifdef PC_ALIGN_TRAP_EN
    logic        misalign;
`endif

    int checks = 0;
    int errors = 0;

    pc_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_off   (branch_off),
        .jump         (jump),
        .jump_tgt     (jump_tgt),
        .halt         (halt),
        .resume       (resume),
`ifdef PC_ALIGN_TRAP_EN
        .misalign     (misalign),
`endif
        .pc           (pc),
        .pc_plus_step (pc_plus_step),
        .fetch_valid  (fetch_valid),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; branch_taken = 0; branch_off = '0;
        jump = 0; jump_tgt = '0; halt = 0; resume = 0;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        #12;
        chk("rst_pc", pc, 32'h0);
        chk("rst_fv", {31'b0, fetch_valid}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_pps", pc_plus_step, 32'h4);
`ifdef PC_ALIGN_TRAP_EN
        chk("rst_misalign", {31'b0, misalign}, 32'd0);
`endif
        rst = 1'b1;
        #2;
        chk("boot_fv", {31'b0, fetch_valid}, 32'd0);
        step();
        chk("boot_exit_pc", pc, 32'h0);
        chk("boot_exit_fv", {31'b0, fetch_valid}, 32'd1);
        step();
        chk("seq_pc4", pc, 32'h4);
        step();
        chk("seq_pc8", pc, 32'h8);
        step();
        step();
        chk("seq_pc10", pc, 32'h10);

        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hold", pc, 32'h10);
        end
        stall = 0;
        step();
        chk("stall_release", pc, 32'h14);

        jump = 1; jump_tgt = 32'h20;
        step();
        chk("jump_20", pc, 32'h20);
        jump = 0; branch_taken = 1; branch_off = 32'hFFFF_FFF8;
        step();
        chk("branch_neg", pc, 32'h18);
        jump = 1; jump_tgt = 32'h100;
        step();
        chk("jump_over_branch", pc, 32'h100);
        idle();
        branch_taken = 1; branch_off = 32'h24;
        step();
        chk("branch_pos", pc, 32'h124);

        idle();
        jump = 1; jump_tgt = 32'hFFFF_FFFC;
        step();
        chk("pre_wrap_pc", pc, 32'hFFFF_FFFC);
        chk("pre_wrap_pps", pc_plus_step, 32'h0);
        idle();
        step();
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_pps", pc_plus_step, 32'h4);

        jump = 1; jump_tgt = 32'h40;
        step();
        idle();
        halt = 1; jump = 1; jump_tgt = 32'h300;
        step();
        chk("halt_over_jump_pc", pc, 32'h40);
        chk("halt_halted", {31'b0, halted}, 32'd1);
        chk("halt_fv", {31'b0, fetch_valid}, 32'd0);
        halt = 0; jump = 1; jump_tgt = 32'h200;
        stall = 1; branch_taken = 1; branch_off = 32'h8;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("halt_hold_pc", pc, 32'h40);
            chk("halt_hold_st", {30'b0, halted, fetch_valid}, 32'd2);
        end
        idle();
        resume = 1; halt = 1;
        step();
        chk("resume_pc", pc, 32'h40);
        chk("resume_st", {30'b0, halted, fetch_valid}, 32'd1);
        idle();
        step();
        chk("resume_seq", pc, 32'h44);

        jump = 1; jump_tgt = 32'h80;
        step();
        idle();
        chk("pre_areset_pc", pc, 32'h80);
        #3;
        rst = 1'b0;
        #1;
        chk("areset_pc", pc, 32'h0);
        chk("areset_fv", {31'b0, fetch_valid}, 32'd0);
        step();
        chk("areset_hold_pc", pc, 32'h0);
        rst = 1'b1;
        step();
        chk("rerun_fv", {31'b0, fetch_valid}, 32'd1);
        step();
        chk("rerun_pc", pc, 32'h4);

`ifdef PC_ALIGN_TRAP_EN
        jump = 1; jump_tgt = 32'h102;
        step();
        idle();
        chk("trap_pc", pc, 32'h4);
        chk("trap_misalign", {31'b0, misalign}, 32'd1);
        chk("trap_halted", {31'b0, halted}, 32'd1);
        resume = 1;
        step();
        idle();
        chk("trap_clear", {31'b0, misalign}, 32'd0);
        chk("trap_resume_pc", pc, 32'h4);
        branch_taken = 1; branch_off = 32'h1;
        step();
        idle();
        chk("trap_br_pc", pc, 32'h4);
        chk("trap_br_misalign", {31'b0, misalign}, 32'd1);
`else
        jump = 1; jump_tgt = 32'h102;
        step();
        idle();
        chk("noalign_pc", pc, 32'h102);
        chk("noalign_halted", {31'b0, halted}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
